mc_control_fsm: RTL and testbench

Parametrised multi-cycle control unit FSM, next generation of the CPU's main controller. It keeps the existing instruction classes, datapath select encodings and Opcode[1:0] dispatch, and adds:
- a MemReq/MemReady memory handshake with optional timeout,
- an illegal-opcode/timeout trap,
- Resume from halt/trap,
- a retired-instruction counter.

It sits between the instruction register opcode field and every datapath mux/write enable.

---
 rtl/mc_control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU main controller: instruction-class sequencing, MemReq/MemReady
// handshake with optional timeout, illegal-opcode/timeout trap, resume and retire counter.
module mc_control_fsm #(
  parameter int OPW     = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [OPW-1:0]   Opcode,
  input  logic             MemReady,
  input  logic             Resume,
  output logic [2:0]       ALU1Op,
  output logic [2:0]       ALU2Op,
  output logic [1:0]       ALU1Src1,
  output logic             ALU1Src2,
  output logic [1:0]       ALU2Src1,
  output logic [1:0]       ALU2Src2,
  output logic             PCSrc,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       CRSrc,
  output logic             CRWrite,
  output logic             SPWrite,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             ALUO1WRT,
  output logic             ALUO2WRT,
  output logic             MemO1WRT,
  output logic             MemO2WRT,
  output logic [1:0]       BType,
  output logic             MemReq,
  output logic             EOP,
  output logic             Trap,
  output logic [1:0]       TrapCause,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_PC_REL    = 4'd1,  S_CB_EXEC   = 4'd2,
    S_CB_MEM    = 4'd3,  S_CB_WB     = 4'd4,  S_ALU_C     = 4'd5,
    S_ALUS_EXEC = 4'd6,  S_ALUS_MEM  = 4'd7,  S_ALUS_WB   = 4'd8,
    S_ALUS_LDS  = 4'd9,  S_ALUS_WRS  = 4'd10, S_REG2REG   = 4'd11,
    S_ABS_BR    = 4'd12, S_HALT      = 4'd13, S_TRAP      = 4'd14
  } state_e;

  // The wait counter only needs to reach the last permitted low cycle.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e             state_r, state_nxt_s;
  logic [WAIT_W-1:0]  wait_r;
  logic [1:0]         cause_r, cause_nxt_s;
  logic [CNT_W-1:0]   retire_cnt_r;
  logic               retire_s, mem_state_s, timeout_s, illegal_s, we_ok_s;
  logic [4:0]         op5_s;

  assign op5_s       = Opcode[4:0];
  assign illegal_s   = (Opcode >> 3'd5) != {OPW{1'b0}};
  assign mem_state_s = (state_r == S_FETCH) || (state_r == S_CB_MEM) || (state_r == S_ALUS_MEM) ||
                       (state_r == S_ALUS_LDS) || (state_r == S_ALUS_WRS);
  assign timeout_s   = (TIMEOUT > 0) && mem_state_s && !MemReady && (wait_r == WAIT_LAST);
  assign we_ok_s     = ~Reset;

  // Next-state, trap cause and retire pulse
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = cause_r;
    case (state_r)
      S_FETCH: begin
        if (!MemReady) begin
          state_nxt_s = S_FETCH;
        end else if (illegal_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = 2'd1;
        end else if (op5_s == 5'b11111) begin
          state_nxt_s = S_PC_REL;
        end else if (op5_s == 5'b11011) begin
          state_nxt_s = S_HALT;
        end else if (op5_s == 5'b11100) begin
          state_nxt_s = S_ABS_BR;
        end else begin
          case (op5_s[1:0])
            2'b00:   state_nxt_s = S_CB_EXEC;
            2'b01:   state_nxt_s = S_ALU_C;
            2'b10:   state_nxt_s = S_ALUS_EXEC;
            2'b11:   state_nxt_s = S_REG2REG;
            default: state_nxt_s = S_FETCH;
          endcase
        end
      end
      S_CB_EXEC:   state_nxt_s = S_CB_MEM;
      S_CB_MEM:    state_nxt_s = MemReady ? S_CB_WB : S_CB_MEM;
      S_ALUS_EXEC: begin
        if (op5_s == 5'b10010) begin
          state_nxt_s = S_ALUS_WRS;
        end else if (op5_s == 5'b11010) begin
          state_nxt_s = S_ALUS_LDS;
        end else begin
          state_nxt_s = S_ALUS_MEM;
        end
      end
      S_ALUS_MEM:  state_nxt_s = MemReady ? S_ALUS_WB : S_ALUS_MEM;
      S_ALUS_LDS:  state_nxt_s = MemReady ? S_FETCH : S_ALUS_LDS;
      S_ALUS_WRS:  state_nxt_s = MemReady ? S_FETCH : S_ALUS_WRS;
      S_HALT:      state_nxt_s = Resume ? S_FETCH : S_HALT;
      S_TRAP: begin
        if (Resume) begin
          state_nxt_s = S_FETCH;
          cause_nxt_s = 2'd0;
        end else begin
          state_nxt_s = S_TRAP;
        end
      end
      default:     state_nxt_s = S_FETCH;
    endcase
    if (timeout_s) begin
      state_nxt_s = S_TRAP;
      cause_nxt_s = 2'd2;
    end else begin
      cause_nxt_s = cause_nxt_s;
    end
    // HALT/TRAP exits and FETCH stalls are not instruction completions
    retire_s = (state_nxt_s == S_FETCH) && (state_r != S_FETCH) &&
               (state_r != S_HALT) && (state_r != S_TRAP);
  end

  // State, wait counter, trap cause and retire counter registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r      <= S_FETCH;
      wait_r       <= {WAIT_W{1'b0}};
      cause_r      <= 2'd0;
      retire_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cause_r <= cause_nxt_s;
      if (state_nxt_s != state_r) begin
        wait_r <= {WAIT_W{1'b0}};
      end else if (mem_state_s && !MemReady && (TIMEOUT > 0)) begin
        wait_r <= wait_r + WAIT_W'(1);
      end else begin
        wait_r <= wait_r;
      end
      if (retire_s) begin
        retire_cnt_r <= retire_cnt_r + CNT_W'(1);
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
    end
  end

  // Datapath controls decoded from state; memory-state enables are MemReady-qualified
  always_comb begin
    ALU1Op = 3'd0;  ALU2Op = 3'd0;  ALU1Src1 = 2'd0; ALU1Src2 = 1'b0;
    ALU2Src1 = 2'd0; ALU2Src2 = 2'd0; PCSrc = 1'b0; PCWrite = 1'b0;
    PCWriteCond = 1'b0; CRSrc = 2'd0; CRWrite = 1'b0; SPWrite = 1'b0;
    IRWrite = 1'b0; MemWrite = 1'b0; ALUO1WRT = 1'b0; ALUO2WRT = 1'b0;
    MemO1WRT = 1'b0; MemO2WRT = 1'b0; BType = 2'd0; MemReq = 1'b0;
    EOP = 1'b0; Trap = 1'b0;
    case (state_r)
      S_FETCH: begin
        MemReq = 1'b1; ALU1Src1 = 2'd1;
        IRWrite = MemReady & we_ok_s; PCWrite = MemReady & we_ok_s;
      end
      S_PC_REL: begin
        PCWrite = we_ok_s; ALU1Src1 = 2'd3;
      end
      S_CB_EXEC: begin
        ALU1Src1 = 2'd2; ALU1Src2 = 1'b1; ALU2Src1 = 2'd2; ALU2Src2 = 2'd1;
        ALUO1WRT = we_ok_s; ALUO2WRT = we_ok_s;
      end
      S_CB_MEM, S_ALUS_MEM: begin
        MemReq = 1'b1; MemO1WRT = MemReady & we_ok_s; MemO2WRT = MemReady & we_ok_s;
      end
      S_CB_WB: begin
        ALU2Src1 = 2'd3; ALU2Src2 = 2'd3; ALU2Op = 3'd1; BType = op5_s[3:2];
        PCSrc = 1'b1; PCWriteCond = we_ok_s;
      end
      S_ALU_C: begin
        ALU2Src1 = 2'd1;
        if (op5_s == 5'b00101) begin
          SPWrite = we_ok_s; ALU2Src2 = 2'd1;
        end else begin
          CRWrite = we_ok_s; CRSrc = 2'd2; ALU2Src2 = 2'd2; ALU2Op = op5_s[4:2];
        end
      end
      S_ALUS_EXEC: begin
        ALU1Src1 = 2'd2; ALU1Src2 = 1'b1; ALUO1WRT = we_ok_s; ALUO2WRT = we_ok_s;
      end
      S_ALUS_WB: begin
        CRWrite = we_ok_s; CRSrc = 2'd2; ALU2Src1 = 2'd3; ALU2Src2 = 2'd2; ALU2Op = op5_s[4:2];
      end
      S_ALUS_LDS: begin
        MemReq = 1'b1; CRWrite = MemReady & we_ok_s; CRSrc = 2'd0;
      end
      S_ALUS_WRS: begin
        MemReq = 1'b1; MemWrite = MemReady & we_ok_s;
      end
      S_REG2REG: begin
        CRWrite = we_ok_s; CRSrc = 2'd1; ALU1Src2 = (op5_s == 5'b01011);
      end
      S_ABS_BR: begin
        PCWrite = we_ok_s; PCSrc = 1'b1;
      end
      S_HALT:  EOP = 1'b1;
      S_TRAP:  Trap = 1'b1;
      default: MemReq = 1'b0;
    endcase
  end

  assign State       = state_r;
  assign TrapCause   = cause_r;
  assign RetireCount = retire_cnt_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed cycle table plus randomized
// run against an instruction-level reference model.
module tb_mc_control_fsm;
  localparam int OPW = 6, CNT_W = 2, TIMEOUT = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Reset, MemReady, Resume;
  logic [OPW-1:0] Opcode;
  logic [2:0] ALU1Op, ALU2Op;
  logic [1:0] ALU1Src1, ALU2Src1, ALU2Src2, CRSrc, BType, TrapCause;
  logic ALU1Src2, PCSrc, PCWrite, PCWriteCond, CRWrite, SPWrite, IRWrite, MemWrite;
  logic ALUO1WRT, ALUO2WRT, MemO1WRT, MemO2WRT, MemReq, EOP, Trap;
  logic [3:0] State;
  logic [CNT_W-1:0] RetireCount;

  mc_control_fsm #(.OPW(OPW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady), .Resume(Resume),
    .ALU1Op(ALU1Op), .ALU2Op(ALU2Op), .ALU1Src1(ALU1Src1), .ALU1Src2(ALU1Src2),
    .ALU2Src1(ALU2Src1), .ALU2Src2(ALU2Src2), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .CRSrc(CRSrc), .CRWrite(CRWrite), .SPWrite(SPWrite),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .ALUO1WRT(ALUO1WRT), .ALUO2WRT(ALUO2WRT),
    .MemO1WRT(MemO1WRT), .MemO2WRT(MemO2WRT), .BType(BType), .MemReq(MemReq),
    .EOP(EOP), .Trap(Trap), .TrapCause(TrapCause), .State(State), .RetireCount(RetireCount)
  );

  typedef struct packed {
    logic [2:0] alu1_op, alu2_op;
    logic [1:0] alu1_src1; logic alu1_src2; logic [1:0] alu2_src1, alu2_src2;
    logic pc_src, pc_write, pc_write_cond;
    logic [1:0] cr_src; logic cr_write, sp_write, ir_write, mem_write;
    logic aluo1, aluo2, memo1, memo2;
    logic [1:0] btype; logic mem_req, eop, trap;
  } outs_t;

  outs_t act_s;
  logic [9:0] we_s;
  assign act_s = {ALU1Op, ALU2Op, ALU1Src1, ALU1Src2, ALU2Src1, ALU2Src2, PCSrc, PCWrite,
                  PCWriteCond, CRSrc, CRWrite, SPWrite, IRWrite, MemWrite, ALUO1WRT, ALUO2WRT,
                  MemO1WRT, MemO2WRT, BType, MemReq, EOP, Trap};
  assign we_s = {IRWrite, PCWrite, PCWriteCond, CRWrite, SPWrite, MemWrite,
                 ALUO1WRT, ALUO2WRT, MemO1WRT, MemO2WRT};

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level plan of remaining phases
  int m_state = 0, m_wait = 0, m_cause = 0, m_retire = 0;
  int m_plan[$];

  task automatic model_step(input logic [5:0] op, input logic mr, input logic res, input logic rst);
    if (rst) begin
      m_state = 0; m_wait = 0; m_cause = 0; m_retire = 0; m_plan.delete();
      return;
    end
    if ((m_state inside {0, 3, 7, 9, 10}) && !mr) begin
      m_wait++;
      if (TIMEOUT > 0 && m_wait == TIMEOUT) begin
        m_state = 14; m_cause = 2; m_wait = 0; m_plan.delete();
      end
      return;
    end
    m_wait = 0;
    case (m_state)
      13: if (res) m_state = 0;
      14: if (res) begin m_state = 0; m_cause = 0; end
      0: begin
        if (op[5]) begin
          m_state = 14; m_cause = 1;
        end else begin
          case (int'(op[4:0]))
            31: m_plan = '{1};
            27: m_plan = '{13};
            28: m_plan = '{12};
            default: case (int'(op[1:0]))
              0: m_plan = '{2, 3, 4};
              1: m_plan = '{5};
              2: if (op[4:0] == 5'b10010) m_plan = '{6, 10};
                 else if (op[4:0] == 5'b11010) m_plan = '{6, 9};
                 else m_plan = '{6, 7, 8};
              default: m_plan = '{11};
            endcase
          endcase
          m_state = m_plan.pop_front();
        end
      end
      default: begin
        if (m_plan.size() > 0) m_state = m_plan.pop_front();
        else begin
          m_state = 0;
          m_retire = (m_retire + 1) % (1 << CNT_W);
        end
      end
    endcase
  endtask

  function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic mr, input logic rst);
    outs_t o = '0;
    case (st)
      0:  begin o.mem_req = 1'b1; o.alu1_src1 = 2'd1; o.ir_write = mr; o.pc_write = mr; end
      1:  begin o.pc_write = 1'b1; o.alu1_src1 = 2'd3; end
      2:  begin o.alu1_src1 = 2'd2; o.alu1_src2 = 1'b1; o.alu2_src1 = 2'd2; o.alu2_src2 = 2'd1;
                o.aluo1 = 1'b1; o.aluo2 = 1'b1; end
      3, 7: begin o.mem_req = 1'b1; o.memo1 = mr; o.memo2 = mr; end
      4:  begin o.alu2_src1 = 2'd3; o.alu2_src2 = 2'd3; o.alu2_op = 3'd1; o.btype = op[3:2];
                o.pc_src = 1'b1; o.pc_write_cond = 1'b1; end
      5:  if (op == 6'b000101) begin o.sp_write = 1'b1; o.alu2_src1 = 2'd1; o.alu2_src2 = 2'd1; end
          else begin o.cr_write = 1'b1; o.cr_src = 2'd2; o.alu2_src1 = 2'd1; o.alu2_src2 = 2'd2;
                o.alu2_op = op[4:2]; end
      6:  begin o.alu1_src1 = 2'd2; o.alu1_src2 = 1'b1; o.aluo1 = 1'b1; o.aluo2 = 1'b1; end
      8:  begin o.cr_write = 1'b1; o.cr_src = 2'd2; o.alu2_src1 = 2'd3; o.alu2_src2 = 2'd2;
                o.alu2_op = op[4:2]; end
      9:  begin o.mem_req = 1'b1; o.cr_write = mr; end
      10: begin o.mem_req = 1'b1; o.mem_write = mr; end
      11: begin o.cr_write = 1'b1; o.cr_src = 2'd1; o.alu1_src2 = (op == 6'b001011); end
      12: begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
      13: o.eop = 1'b1;
      14: o.trap = 1'b1;
      default: o = '0;
    endcase
    if (rst) begin
      o.pc_write = 1'b0; o.pc_write_cond = 1'b0; o.cr_write = 1'b0; o.sp_write = 1'b0;
      o.ir_write = 1'b0; o.mem_write = 1'b0; o.aluo1 = 1'b0; o.aluo2 = 1'b0;
      o.memo1 = 1'b0; o.memo2 = 1'b0;
    end
    return o;
  endfunction

  logic [5:0] cur_op;
  logic cur_mr, cur_res, cur_rst;

  task automatic apply(input logic [5:0] op, input logic mr, input logic res, input logic rst);
    cur_op = op; cur_mr = mr; cur_res = res; cur_rst = rst;
    Opcode = op; MemReady = mr; Resume = res; Reset = rst;
    #1;
  endtask

  task automatic model_checks();
    chk("outputs", {1'b0, act_s}, {1'b0, exp_out(m_state, cur_op, cur_mr, cur_rst)});
    chk("State", 32'(State), 32'(m_state));
    chk("TrapCause", 32'(TrapCause), 32'(m_cause));
    chk("RetireCount", 32'(RetireCount), 32'(m_retire));
  endtask

  task automatic end_cycle();
    model_step(cur_op, cur_mr, cur_res, cur_rst);
    @(negedge CLK);
  endtask

  typedef struct {
    bit rst; logic [5:0] op; bit mr; bit res;
    int st; int cause; int cnt; logic [9:0] we; logic [1:0] bt;
  } vec_t;

  function automatic vec_t mk(input bit rst, input logic [5:0] op, input bit mr, input bit res,
                              input int st, input int cause, input int cnt,
                              input logic [9:0] we, input logic [1:0] bt);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.res = res; v.st = st;
    v.cause = cause; v.cnt = cnt; v.we = we; v.bt = bt;
    return v;
  endfunction

  // Write-enable order: IR PC PCC CR SP MW AO1 AO2 MO1 MO2
  localparam logic [9:0] W_0 = 10'b0000000000, W_FE = 10'b1100000000, W_SP = 10'b0000100000,
    W_ALUO = 10'b0000001100, W_MEMO = 10'b0000000011, W_MW = 10'b0000010000,
    W_PCC = 10'b0010000000, W_PC = 10'b0100000000, W_CR = 10'b0001000000;

  vec_t tbl[$];
  int ready_pct;
  logic [5:0] r_op;

  initial begin
    // ALU_C, ALUS_WRS with 3 stalls, CB paths and BType
    tbl.push_back(mk(0, 6'b000101, 1, 0, 0, 0, 0, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b000101, 1, 0, 5, 0, 0, W_SP, 2'd0));
    tbl.push_back(mk(0, 6'b010010, 1, 0, 0, 0, 1, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b010010, 1, 0, 6, 0, 1, W_ALUO, 2'd0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 6'b010010, 0, 0, 10, 0, 1, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b010010, 1, 0, 10, 0, 1, W_MW, 2'd0));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 0, 0, 2, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 2, 0, 2, W_ALUO, 2'd0));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 3, 0, 2, W_MEMO, 2'd0));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 4, 0, 2, W_PCC, 2'd0));
    tbl.push_back(mk(0, 6'b001100, 1, 0, 0, 0, 3, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b001100, 1, 0, 2, 0, 3, W_ALUO, 2'd0));
    tbl.push_back(mk(0, 6'b001100, 1, 0, 3, 0, 3, W_MEMO, 2'd0));
    tbl.push_back(mk(0, 6'b001100, 1, 0, 4, 0, 3, W_PCC, 2'd3));
    // Counter wrapped; illegal opcode trap, resume, halt with resume
    tbl.push_back(mk(0, 6'b100001, 1, 0, 0, 0, 0, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b100001, 1, 0, 14, 1, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b100001, 1, 1, 14, 1, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b011011, 1, 1, 0, 0, 0, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b011011, 1, 0, 13, 0, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b011011, 1, 0, 13, 0, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b011011, 1, 1, 13, 0, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b011100, 1, 0, 0, 0, 0, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b011100, 1, 0, 12, 0, 0, W_PC, 2'd0));
    tbl.push_back(mk(0, 6'b011111, 1, 0, 0, 0, 1, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b011111, 1, 0, 1, 0, 1, W_PC, 2'd0));
    tbl.push_back(mk(0, 6'b011010, 1, 0, 0, 0, 2, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b011010, 1, 0, 6, 0, 2, W_ALUO, 2'd0));
    tbl.push_back(mk(0, 6'b011010, 0, 0, 9, 0, 2, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b011010, 1, 0, 9, 0, 2, W_CR, 2'd0));
    tbl.push_back(mk(0, 6'b000011, 1, 0, 0, 0, 3, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b000011, 1, 0, 11, 0, 3, W_CR, 2'd0));
    // Fetch timeout after four low cycles, then resume
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 6'b000101, 0, 0, 0, 0, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b000101, 0, 0, 14, 2, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b000101, 0, 1, 14, 2, 0, W_0, 2'd0));
    // Reset while in CB_MEM with MemReady high: no enables, back to FETCH
    tbl.push_back(mk(0, 6'b000000, 1, 0, 0, 0, 0, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b000000, 1, 0, 2, 0, 0, W_ALUO, 2'd0));
    tbl.push_back(mk(0, 6'b000000, 0, 0, 3, 0, 0, W_0, 2'd0));
    tbl.push_back(mk(1, 6'b000000, 1, 0, 3, 0, 0, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b000101, 1, 0, 0, 0, 0, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b000101, 1, 0, 5, 0, 0, W_SP, 2'd0));
    // ALUS_MEM path; MemReady after three stalls beats the limit
    tbl.push_back(mk(0, 6'b000010, 1, 0, 0, 0, 1, W_FE, 2'd0));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 6, 0, 1, W_ALUO, 2'd0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 6'b000010, 0, 0, 7, 0, 1, W_0, 2'd0));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 7, 0, 1, W_MEMO, 2'd0));
    tbl.push_back(mk(0, 6'b000010, 1, 0, 8, 0, 1, W_CR, 2'd0));
    tbl.push_back(mk(0, 6'b000101, 1, 0, 0, 0, 2, W_FE, 2'd0));

    Reset = 1'b1; MemReady = 1'b0; Resume = 1'b0; Opcode = '0;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      apply(6'b000000, 1'b0, 1'b0, 1'b1);
      end_cycle();
    end

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].mr, tbl[i].res, tbl[i].rst);
      chk($sformatf("row%0d State", i), 32'(State), 32'(tbl[i].st));
      chk($sformatf("row%0d TrapCause", i), 32'(TrapCause), 32'(tbl[i].cause));
      chk($sformatf("row%0d RetireCount", i), 32'(RetireCount), 32'(tbl[i].cnt));
      chk($sformatf("row%0d enables", i), 32'(we_s), 32'(tbl[i].we));
      chk($sformatf("row%0d BType", i), 32'(BType), 32'(tbl[i].bt));
      model_checks();
      end_cycle();
    end

    // Randomized run against the model; Opcode only changes between instructions
    ready_pct = 95;
    r_op = 6'b000101;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ready_pct = (n % 300 == 0) ? 95 : ((n % 300 == 100) ? 60 : 25);
      if (m_state inside {0, 13, 14}) begin
        if ($urandom_range(0, 9) == 0) r_op = 6'($urandom_range(0, 63));
        else r_op = {1'b0, 5'($urandom_range(0, 31))};
      end
      apply(r_op, ($urandom_range(0, 99) < ready_pct), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 199) == 0));
      model_checks();
      end_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
